// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer for the encoder / channel / Viterbi decoder chain: payload pull, tail insertion,
// decoder-latency tag tracking and bit-error counting. Optional macro: VITERBI_FRAME_CTRL_FIRST_ERR_EN.
module viterbi_frame_ctrl #(
   parameter int unsigned FRAME_LEN = 256,
   parameter int unsigned TAIL_LEN  = 2,
   parameter int unsigned DEC_LAT   = 16,
   parameter int unsigned CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic             src_valid_i,
   input  logic             src_data_i,
   output logic             src_ready_o,
   output logic             enc_enable_o,
   output logic             enc_d_o,
   input  logic             dec_d_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [CNT_W-1:0] bit_err_ct_o,
   output logic [CNT_W-1:0] frame_ct_o
`ifdef VITERBI_FRAME_CTRL_FIRST_ERR_EN
   ,
   output logic                           first_err_vld_o,
   output logic [$clog2(FRAME_LEN)-1:0]   first_err_idx_o
`endif
);

   localparam int unsigned IDX_W     = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam int unsigned TW        = (TAIL_LEN > 0) ? $clog2(TAIL_LEN + 1) : 1;
   localparam int unsigned TAIL_LAST = (TAIL_LEN > 0) ? TAIL_LEN - 1 : 0;

   typedef enum logic [2:0] {S_IDLE, S_PAYLOAD, S_TAIL, S_DRAIN, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   pay_idx_q, pay_idx_d;
   logic [TW-1:0]      tail_cnt_q, tail_cnt_d;
   logic               enc_tag_q, enc_tag_d;
   logic               enc_enable_d, enc_d_d, done_d, busy_d, line_clr;
   logic [CNT_W-1:0]   err_ct_d, frame_ct_d;
   logic               accept, cmp_err, line_empty;

   // Delay line: valid marks any encoder bit, tag marks payload bits only
   logic [DEC_LAT-1:0] dl_vld_q, dl_tag_q, dl_bit_q;
   logic [DEC_LAT-1:0] dl_vld_n, dl_tag_n, dl_bit_n;

   assign accept     = src_valid_i & src_ready_o;
   assign cmp_err    = dl_tag_q[DEC_LAT-1] & (dec_d_i != dl_bit_q[DEC_LAT-1]);
   assign line_empty = ~(|dl_vld_q) & ~enc_enable_o;

`ifdef VITERBI_FRAME_CTRL_FIRST_ERR_EN
   logic [IDX_W-1:0]              enc_idx_q, enc_idx_d;
   logic [DEC_LAT-1:0][IDX_W-1:0] dl_idx_q, dl_idx_n;
   logic                          fe_vld_d;
   logic [IDX_W-1:0]              fe_idx_d;
`endif

   generate
      if (DEC_LAT == 1) begin : g_dl_one
         assign dl_vld_n = enc_enable_o;
         assign dl_tag_n = enc_tag_q;
         assign dl_bit_n = enc_d_o;
`ifdef VITERBI_FRAME_CTRL_FIRST_ERR_EN
         assign dl_idx_n = enc_idx_q;
`endif
      end else begin : g_dl_many
         assign dl_vld_n = {dl_vld_q[DEC_LAT-2:0], enc_enable_o};
         assign dl_tag_n = {dl_tag_q[DEC_LAT-2:0], enc_tag_q};
         assign dl_bit_n = {dl_bit_q[DEC_LAT-2:0], enc_d_o};
`ifdef VITERBI_FRAME_CTRL_FIRST_ERR_EN
         assign dl_idx_n = {dl_idx_q[DEC_LAT-2:0], enc_idx_q};
`endif
      end
   endgenerate

   // Next-state and next-output logic
   always_comb begin
      state_d      = state_q;
      pay_idx_d    = pay_idx_q;
      tail_cnt_d   = tail_cnt_q;
      enc_enable_d = 1'b0;
      enc_d_d      = enc_d_o;
      enc_tag_d    = 1'b0;
      done_d       = 1'b0;
      err_ct_d     = bit_err_ct_o;
      frame_ct_d   = frame_ct_o;
      src_ready_o  = 1'b0;
      line_clr     = 1'b0;
`ifdef VITERBI_FRAME_CTRL_FIRST_ERR_EN
      enc_idx_d    = enc_idx_q;
      fe_vld_d     = first_err_vld_o;
      fe_idx_d     = first_err_idx_o;
      if (cmp_err && !first_err_vld_o) begin
         fe_vld_d = 1'b1;
         fe_idx_d = dl_idx_q[DEC_LAT-1];
      end
`endif
      if (cmp_err && (bit_err_ct_o != '1)) err_ct_d = bit_err_ct_o + CNT_W'(1);

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d   = S_PAYLOAD;
               pay_idx_d = '0;
               err_ct_d  = '0;
`ifdef VITERBI_FRAME_CTRL_FIRST_ERR_EN
               fe_vld_d  = 1'b0;
               fe_idx_d  = '0;
`endif
            end
         end
         S_PAYLOAD: begin
            src_ready_o = 1'b1;
            if (accept) begin
               enc_enable_d = 1'b1;
               enc_d_d      = src_data_i;
               enc_tag_d    = 1'b1;
               pay_idx_d    = pay_idx_q + IDX_W'(1);
`ifdef VITERBI_FRAME_CTRL_FIRST_ERR_EN
               enc_idx_d    = pay_idx_q;
`endif
               if (pay_idx_q == IDX_W'(FRAME_LEN - 1)) begin
                  state_d    = (TAIL_LEN > 0) ? S_TAIL : S_DRAIN;
                  tail_cnt_d = '0;
               end
            end
         end
         S_TAIL: begin
            enc_enable_d = 1'b1;
            enc_d_d      = 1'b0;
            tail_cnt_d   = tail_cnt_q + TW'(1);
            if (tail_cnt_q == TW'(TAIL_LAST)) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (line_empty) begin
               state_d    = S_DONE;
               done_d     = 1'b1;
               frame_ct_d = frame_ct_o + CNT_W'(1);
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Abort overrides everything; counters and first-error capture hold
      if (abort_i) begin
         state_d      = S_IDLE;
         enc_enable_d = 1'b0;
         enc_d_d      = enc_d_o;
         enc_tag_d    = 1'b0;
         done_d       = 1'b0;
         err_ct_d     = bit_err_ct_o;
         frame_ct_d   = frame_ct_o;
         line_clr     = 1'b1;
`ifdef VITERBI_FRAME_CTRL_FIRST_ERR_EN
         fe_vld_d     = first_err_vld_o;
         fe_idx_d     = first_err_idx_o;
`endif
      end
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         pay_idx_q    <= '0;
         tail_cnt_q   <= '0;
         enc_tag_q    <= 1'b0;
         enc_enable_o <= 1'b0;
         enc_d_o      <= 1'b0;
         busy_o       <= 1'b0;
         done_o       <= 1'b0;
         bit_err_ct_o <= '0;
         frame_ct_o   <= '0;
      end else begin
         state_q      <= state_d;
         pay_idx_q    <= pay_idx_d;
         tail_cnt_q   <= tail_cnt_d;
         enc_tag_q    <= enc_tag_d;
         enc_enable_o <= enc_enable_d;
         enc_d_o      <= enc_d_d;
         busy_o       <= busy_d;
         done_o       <= done_d;
         bit_err_ct_o <= err_ct_d;
         frame_ct_o   <= frame_ct_d;
      end
   end

   // Delay line shifts every cycle; abort flushes it
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dl_vld_q <= '0;
         dl_tag_q <= '0;
         dl_bit_q <= '0;
      end else if (line_clr) begin
         dl_vld_q <= '0;
         dl_tag_q <= '0;
         dl_bit_q <= '0;
      end else begin
         dl_vld_q <= dl_vld_n;
         dl_tag_q <= dl_tag_n;
         dl_bit_q <= dl_bit_n;
      end
   end

`ifdef VITERBI_FRAME_CTRL_FIRST_ERR_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         enc_idx_q       <= '0;
         dl_idx_q        <= '0;
         first_err_vld_o <= 1'b0;
         first_err_idx_o <= '0;
      end else begin
         enc_idx_q       <= enc_idx_d;
         dl_idx_q        <= line_clr ? '0 : dl_idx_n;
         first_err_vld_o <= fe_vld_d;
         first_err_idx_o <= fe_idx_d;
      end
   end
`endif

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Directed bench for viterbi_frame_ctrl: ideal/corrupting channel models, abort, back-to-back and saturation cases.
module tb_viterbi_frame_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   // Main instance: FRAME_LEN=16, TAIL_LEN=2, DEC_LAT=4, CNT_W=16
   logic        start_i = 1'b0, abort_i = 1'b0, src_valid_i = 1'b0, src_data_i = 1'b0;
   logic        src_ready_o, enc_enable_o, enc_d_o, dec_d_i, busy_o, done_o;
   logic [15:0] bit_err_ct_o, frame_ct_o;
`ifdef VITERBI_FRAME_CTRL_FIRST_ERR_EN
   logic        first_err_vld_o;
   logic [3:0]  first_err_idx_o;
`endif

   viterbi_frame_ctrl #(.FRAME_LEN(16), .TAIL_LEN(2), .DEC_LAT(4), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
      .src_valid_i(src_valid_i), .src_data_i(src_data_i), .src_ready_o(src_ready_o),
      .enc_enable_o(enc_enable_o), .enc_d_o(enc_d_o), .dec_d_i(dec_d_i),
      .busy_o(busy_o), .done_o(done_o), .bit_err_ct_o(bit_err_ct_o), .frame_ct_o(frame_ct_o)
`ifdef VITERBI_FRAME_CTRL_FIRST_ERR_EN
      , .first_err_vld_o(first_err_vld_o), .first_err_idx_o(first_err_idx_o)
`endif
   );

   // Second instance: no tail, 2-bit counters, channel inverts every bit
   logic        start2 = 1'b0;
   logic        ready2, enc2_en, enc2_d, dec2_d, busy2, done2;
   logic [1:0]  err2, frame2;
`ifdef VITERBI_FRAME_CTRL_FIRST_ERR_EN
   logic        fe2_vld;
   logic [3:0]  fe2_idx;
`endif

   viterbi_frame_ctrl #(.FRAME_LEN(16), .TAIL_LEN(0), .DEC_LAT(4), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .start_i(start2), .abort_i(1'b0),
      .src_valid_i(1'b1), .src_data_i(1'b1), .src_ready_o(ready2),
      .enc_enable_o(enc2_en), .enc_d_o(enc2_d), .dec_d_i(dec2_d),
      .busy_o(busy2), .done_o(done2), .bit_err_ct_o(err2), .frame_ct_o(frame2)
`ifdef VITERBI_FRAME_CTRL_FIRST_ERR_EN
      , .first_err_vld_o(fe2_vld), .first_err_idx_o(fe2_idx)
`endif
   );

   // Channel models: 4-cycle delay of encoder output, optional per-index corruption
   logic [31:0] mask = '0;
   logic [3:0]  ch_vld = '0, ch_bit = '0, ch2_bit = '0;
   logic [4:0]  ch_idx [4];
   logic [4:0]  enc_n = '0;
   initial for (int i = 0; i < 4; i++) ch_idx[i] = '0;

   always @(posedge clk) begin
      ch_vld    <= {ch_vld[2:0], enc_enable_o};
      ch_bit    <= {ch_bit[2:0], enc_d_o};
      ch_idx[0] <= enc_n;
      for (int i = 1; i < 4; i++) ch_idx[i] <= ch_idx[i-1];
      if (start_i && !busy_o) enc_n <= '0;
      else if (enc_enable_o)  enc_n <= enc_n + 5'd1;
      ch2_bit   <= {ch2_bit[2:0], enc2_d};
   end
   assign dec_d_i = ch_bit[3] ^ (ch_vld[3] & mask[ch_idx[3]]);
   assign dec2_d  = ~ch2_bit[3];

   int n_cmp = 0;
   int n_fail = 0;
   logic [15:0] payload = 16'hB6CB;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Runs one frame on the main instance from an IDLE negedge; abort_at>=0 aborts before that payload index
   task automatic run_frame(input bit toggle, input int abort_at, output int done_at, output int en_cnt,
                            output int max_run, output int bad_bits, output logic [2:0] hist);
      int acc, run, k;
      acc = 0; run = 0; k = 0;
      done_at = -1; en_cnt = 0; max_run = 0; bad_bits = 0; hist = '0;
      start_i = 1'b1; src_valid_i = 1'b1; src_data_i = payload[0];
      for (int n = 0; n < 80; n++) begin
         @(negedge clk);
         start_i = 1'b0;
         if (enc_enable_o) begin
            en_cnt++; run++; hist = {hist[1:0], enc_d_o};
            if (run > max_run) max_run = run;
            if (k < 16 && enc_d_o !== payload[k]) bad_bits++;
            k++;
         end else run = 0;
         if (done_o) begin
            done_at = n;
            break;
         end
         src_valid_i = toggle ? (n % 2 == 0) : 1'b1;
         src_data_i  = (acc < 16) ? payload[acc] : 1'b0;
         if (abort_at >= 0 && acc == abort_at) begin
            abort_i = 1'b1;
            @(negedge clk);
            abort_i = 1'b0;
            src_valid_i = 1'b0;
            return;
         end
         if (src_valid_i && src_ready_o) acc++;
      end
      src_valid_i = 1'b0;
   endtask

   int d_at, en_c, mrun, bad, dcnt, d1, d2;
   logic [2:0] hst;

   initial begin
      repeat (3) @(negedge clk);
      // Reset state
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_enc_en", enc_enable_o, 0);
      chk("rst_enc_d", enc_d_o, 0);
      chk("rst_ready", src_ready_o, 0);
      chk("rst_err", bit_err_ct_o, 0);
      chk("rst_frame", frame_ct_o, 0);
      chk("rst_err2", err2, 0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // 1: ideal channel, no stalls
      mask = '0;
      run_frame(1'b0, -1, d_at, en_c, mrun, bad, hst);
      chk("t1_done_at", d_at, 24);
      chk("t1_err", bit_err_ct_o, 0);
      chk("t1_frame", frame_ct_o, 1);
      chk("t1_enc_cnt", en_c, 18);
      chk("t1_enc_run", mrun, 18);
      chk("t1_enc_bits", bad, 0);
      chk("t1_tail_bits", hst, 3'b100);
      repeat (2) @(negedge clk);

      // 2: payload indices 3 and 9 plus first tail slot corrupted
      mask = '0; mask[3] = 1'b1; mask[9] = 1'b1; mask[16] = 1'b1;
      run_frame(1'b0, -1, d_at, en_c, mrun, bad, hst);
      chk("t2_done_at", d_at, 24);
      chk("t2_err", bit_err_ct_o, 2);
      chk("t2_frame", frame_ct_o, 2);
`ifdef VITERBI_FRAME_CTRL_FIRST_ERR_EN
      chk("t2_fe_vld", first_err_vld_o, 1);
      chk("t2_fe_idx", first_err_idx_o, 3);
`endif
      repeat (2) @(negedge clk);

      // 3: source valid toggling 1,0,1,0...
      run_frame(1'b1, -1, d_at, en_c, mrun, bad, hst);
      chk("t3_done_at", d_at, 39);
      chk("t3_enc_cnt", en_c, 18);
      chk("t3_enc_run", mrun, 3);
      chk("t3_enc_bits", bad, 0);
      chk("t3_err", bit_err_ct_o, 2);
      chk("t3_frame", frame_ct_o, 3);
      repeat (2) @(negedge clk);

      // 4: abort before payload index 7, index 1 corrupted (already compared)
      mask = '0; mask[1] = 1'b1;
      run_frame(1'b0, 7, d_at, en_c, mrun, bad, hst);
      chk("t4_busy", busy_o, 0);
      chk("t4_ready", src_ready_o, 0);
      chk("t4_enc_en", enc_enable_o, 0);
      chk("t4_err_hold", bit_err_ct_o, 1);
      dcnt = 0;
      for (int n = 0; n < 30; n++) begin
         @(negedge clk);
         if (done_o) dcnt++;
      end
      chk("t4_no_done", dcnt, 0);
      chk("t4_frame", frame_ct_o, 3);
      mask = '0;
      run_frame(1'b0, -1, d_at, en_c, mrun, bad, hst);
      chk("t4b_done_at", d_at, 24);
      chk("t4b_err", bit_err_ct_o, 0);
      chk("t4b_frame", frame_ct_o, 4);
      repeat (2) @(negedge clk);

      // 5: start held high -> back-to-back frames
      start_i = 1'b1; src_valid_i = 1'b1; src_data_i = 1'b1;
      dcnt = 0; d1 = -1; d2 = -1;
      for (int n = 0; n <= 50; n++) begin
         @(negedge clk);
         if (done_o) begin
            dcnt++;
            if (d1 < 0) d1 = n; else d2 = n;
         end
      end
      start_i = 1'b0; src_valid_i = 1'b0;
      chk("t5_done1", d1, 24);
      chk("t5_done2", d2, 50);
      chk("t5_done_cnt", dcnt, 2);
      chk("t5_frame", frame_ct_o, 6);

      // 6: no tail, every payload bit corrupted, 2-bit counter saturates
      start2 = 1'b1;
      d_at = -1; en_c = 0;
      for (int n = 0; n < 60; n++) begin
         @(negedge clk);
         start2 = 1'b0;
         if (enc2_en) en_c++;
         if (done2) begin
            d_at = n;
            break;
         end
      end
      chk("t6_done_at", d_at, 22);
      chk("t6_enc_cnt", en_c, 16);
      chk("t6_err_sat", err2, 3);
      chk("t6_frame", frame2, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
